// File: rtl/slt_sort_ctrl.sv
// Batch bubble sorter: loads DEPTH signed words, sorts them in place with one shared
// signed less-than compare per cycle, then streams them out in ascending order.
module slt_sort_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LastJ   = IW'(DEPTH - 2);

    typedef enum logic [1:0] {
        StLoad,
        StSort,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    wcnt_q, wcnt_d;
    logic [IW-1:0]    j_q, j_d;
    logic [IW-1:0]    pass_q, pass_d;
    logic [IW-1:0]    rd_q, rd_d;
    logic             swapped_q, swapped_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [IW-1:0]    j_inc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] diff;
    logic             lt;
    logic             pass_swapped;

    // Shared comparator: a = mem[j+1], b = mem[j]. The subtract sign is only trusted
    // when the operands share a sign; otherwise the operand MSBs decide directly.
    assign j_inc = j_q + IW'(1);
    assign op_a  = mem_q[j_inc];
    assign op_b  = mem_q[j_q];
    assign diff  = op_a - op_b;
    assign lt    = (diff[WIDTH-1] & ~(op_a[WIDTH-1] ^ op_b[WIDTH-1]))
                 | (op_a[WIDTH-1] & ~op_b[WIDTH-1]);
    assign pass_swapped = swapped_q | lt;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        j_d       = j_q;
        pass_d    = pass_q;
        rd_d      = rd_q;
        swapped_d = swapped_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        unique case (state_q)
            StLoad: begin
                if (in_valid) begin
                    mem_d[wcnt_q] = in_data;
                    if (wcnt_q == LastIdx) begin
                        state_d   = StSort;
                        wcnt_d    = '0;
                        j_d       = '0;
                        pass_d    = '0;
                        swapped_d = 1'b0;
                    end else begin
                        wcnt_d = wcnt_q + IW'(1);
                    end
                end
            end
            StSort: begin
                if (lt) begin
                    mem_d[j_q]   = op_a;
                    mem_d[j_inc] = op_b;
                end
                if (j_q == LastJ) begin
                    // A clean pass means sorted; DEPTH-1 passes always suffice.
                    if (!pass_swapped || (pass_q == LastJ)) begin
                        state_d = StDrain;
                        rd_d    = '0;
                    end else begin
                        pass_d = pass_q + IW'(1);
                    end
                    j_d       = '0;
                    swapped_d = 1'b0;
                end else begin
                    j_d       = j_inc;
                    swapped_d = pass_swapped;
                end
            end
            StDrain: begin
                if (out_ready) begin
                    if (rd_q == LastIdx) begin
                        state_d = StLoad;
                        rd_d    = '0;
                        wcnt_d  = '0;
                    end else begin
                        rd_d = rd_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StLoad;
            wcnt_q    <= '0;
            j_q       <= '0;
            pass_q    <= '0;
            rd_q      <= '0;
            swapped_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            j_q       <= j_d;
            pass_q    <= pass_d;
            rd_q      <= rd_d;
            swapped_q <= swapped_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // All outputs decode registered state only.
    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StDrain);
    assign busy      = (state_q == StSort);
    assign out_data  = (state_q == StDrain) ? mem_q[rd_q] : '0;

endmodule
